// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial N-bit subtractor (diff = a - b, LSB first) with start/busy/done handshake.
// Optional signed-overflow output ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   sa_q, sa_d;
  logic [N-1:0]   sb_q, sb_d;
  logic [N-1:0]   res_q, res_d;
  logic [N-1:0]   diff_q, diff_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           br_q, br_d;
  logic           bout_q, bout_d;

  logic           bit_diff;
  logic           br_next;
  logic [N-1:0]   res_shift;

`ifdef SERIAL_SUB_OVF_EN
  logic           asign_q, asign_d;
  logic           bsign_q, bsign_d;
  logic           ovf_q, ovf_d;
`endif

  // One full-subtractor cell operating on the current LSBs and the stored borrow.
  always_comb begin
    bit_diff  = sa_q[0] ^ sb_q[0] ^ br_q;
    br_next   = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    res_shift = res_q >> 1;
    res_shift[N-1] = bit_diff;
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    asign_d = asign_q;
    bsign_d = bsign_q;
    ovf_d   = ovf_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          res_d   = '0;
          diff_d  = '0;
          cnt_d   = '0;
          br_d    = 1'b0;
          bout_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
          asign_d = a[N-1];
          bsign_d = b[N-1];
          ovf_d   = 1'b0;
`endif
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        res_d = res_shift;
        br_d  = br_next;
        cnt_d = cnt_q + CW'(1);
        // Last bit: publish the completed result together with the final borrow.
        if (cnt_q == CW'(N - 1)) begin
          diff_d  = res_shift;
          bout_d  = br_next;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (asign_q != bsign_q) && (res_shift[N-1] != asign_q);
`endif
          state_d = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      asign_q <= 1'b0;
      bsign_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      asign_q <= asign_d;
      bsign_q <= bsign_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor (N=8 and N=1 instances).
// Define SERIAL_SUB_OVF_EN to also check the ovf output.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done, bout;
  logic [7:0] diff;

  logic       start1;
  logic [0:0] a1, b1;
  logic       busy1, done1, bout1;
  logic [0:0] diff1;

`ifdef SERIAL_SUB_OVF_EN
  logic       ovf, ovf1;
`endif

  int checks   = 0;
  int failures = 0;
  int lat, bc;

  always #5 clk = ~clk;

  serial_subtractor #(.N(8)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  serial_subtractor #(.N(1)) u_dut_n1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .busy  (busy1),
    .done  (done1),
    .diff  (diff1),
    .bout  (bout1)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [7:0] ed,
                        input logic ebo, input logic eov);
    int l, n;
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~ta; b = ~tb_v;
    check("diff_cleared_on_start", diff, 8'h00);
    l = 1; n = 0;
    while (!done && l < 20) begin
      if (busy) n++;
      @(negedge clk);
      l++;
    end
    check("latency", l, 9);
    check("busy_cycles", n, 8);
    check("busy_low_at_done", busy, 0);
    check("diff", diff, ed);
    check("bout", bout, ebo);
`ifdef SERIAL_SUB_OVF_EN
    check("ovf", ovf, eov);
`else
    if (eov === 1'bx) check("ovf_vector", eov, 0);
`endif
  endtask

  logic [7:0] va [7] = '{8'h05, 8'h03, 8'h00, 8'hFF, 8'h80, 8'h7F, 8'h10};
  logic [7:0] vb [7] = '{8'h03, 8'h05, 8'h00, 8'hFF, 8'h01, 8'hFF, 8'h01};
  logic [7:0] vd [7] = '{8'h02, 8'hFE, 8'h00, 8'h00, 8'h7F, 8'h80, 8'h0F};
  logic       vbo[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       vov[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  logic [3:0] n1_diff = 4'b0110;
  logic [3:0] n1_bout = 4'b0010;
  logic [3:0] n1_ovf  = 4'b0010;

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_op(va[i], vb[i], vd[i], vbo[i], vov[i]);

    // Result must hold through IDLE.
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("idle_hold_diff", diff, 8'hFE);
    check("idle_hold_bout", bout, 1);
    check("idle_done_low", done, 0);

    // start held high with operands changing during RUN, then back-to-back restart from DONE.
    @(negedge clk);
    a = 8'h05; b = 8'h03; start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      a = 8'($urandom); b = 8'($urandom);
    end while (!done && lat < 20);
    check("held_start_latency", lat, 9);
    check("held_start_diff", diff, 8'h02);
    check("held_start_bout", bout, 0);
    a = 8'h03; b = 8'h05;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", busy, 1);
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_latency", lat + 1, 9 + 1);
    check("b2b_diff", diff, 8'hFE);
    check("b2b_bout", bout, 1);

    // Reset in the 4th RUN cycle discards the operation.
    @(negedge clk);
    a = 8'h55; b = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_diff", diff, 0);
    check("midrst_bout", bout, 0);
    bc = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || done) bc++;
    end
    check("midrst_stays_idle", bc, 0);
    run_op(8'h20, 8'h10, 8'h10, 1'b0, 1'b0);

    // N=1 instance, exhaustive.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a1 = 1'(i >> 1); b1 = 1'(i); start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      check("n1_busy", busy1, 1);
      check("n1_done_early", done1, 0);
      @(negedge clk);
      check("n1_done", done1, 1);
      check("n1_diff", diff1, n1_diff[i]);
      check("n1_bout", bout1, n1_bout[i]);
`ifdef SERIAL_SUB_OVF_EN
      check("n1_ovf", ovf1, n1_ovf[i]);
`else
      if (n1_ovf[i] === 1'bx) check("n1_ovf_vector", n1_ovf[i], 0);
`endif
      @(negedge clk);
      check("n1_done_pulse", done1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor; computes diff = a - b, LSB first, one bit per clock.
- Uses one full-subtractor cell (the inverse of the full adder) plus a borrow flip-flop.
- Sits beside the adder chain as the area-cheap subtract path.
- Uses a start/busy/done handshake so a controller can sequence operations.

Parameters:
- N, 8, operand and result width in bits (N >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request to begin an operation; sampled only in IDLE or DONE.
- a  input  N  minuend; sampled on the accepted start cycle.
- b  input  N  subtrahend; sampled on the accepted start cycle.
- busy  output  1  high while bits are being processed (RUN).
- done  output  1  one-cycle pulse when diff/bout become valid.
- diff  output  N  result a - b mod 2^N; held until the next accepted start.
- bout  output  1  final borrow; 1 when a < b (unsigned).

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: on a clk edge with rst=1, go to IDLE; busy=0, done=0, diff=0, bout=0, bit counter=0, borrow FF=0.
- rst overrides every other input, including in mid-operation; the partial result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 loads a into shift register SA and b into SB, clears the borrow FF and the counter, and clears diff to 0; next state is RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - d = SA[0]^SB[0]^br.
  - br_next = (~SA[0]&SB[0]) | (~(SA[0]^SB[0])&br).
  - SA and SB shift right by 1; the result register shifts right with d entering at bit N-1.
  - The counter increments.
  - On the cycle the counter reaches N-1, the result is complete: next state is DONE and bout <= br_next.
  - start is ignored in RUN; a and b may change freely.
- DONE:
  - done=1 for exactly this one cycle; busy=0.
  - start=1 behaves as in IDLE: load the operands and go to RUN, with no idle gap required.
  - Otherwise next state is IDLE.
- Latency: start accepted on edge t; busy=1 for cycles t+1 .. t+N; done=1 in cycle t+N+1.
  - Throughput: one result per N+1 cycles with back-to-back starts.
- diff and bout change only on reset, on an accepted start (diff clears to 0), and at the RUN→DONE edge. They hold their value in IDLE.
- Boundary N=1: RUN lasts exactly one cycle.
- Arithmetic:
  - All N bits are processed; no early exit on zero operands.
  - Wrap-around is modulo 2^N.
  - bout equals bit N of (a - b) computed in N+1 bits.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Extra output port ovf (output, 1 bit): two's-complement signed overflow of a - b.
  - ovf = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]), using the sampled operand sign bits.
  - ovf is registered alongside bout at the RUN→DONE edge, and follows bout's reset/clear/hold rules.
- Not defined: the ovf port and its logic are absent. All other behaviour is identical.

Test Plan:
- N=8, a=0x05, b=0x03, pulse start → busy high for 8 cycles, done at start+9, diff=0x02, bout=0.
- N=8, a=0x03, b=0x05 → diff=0xFE, bout=1. a=0x00, b=0x00 → diff=0x00, bout=0. a=0xFF, b=0xFF → diff=0x00, bout=0.
- With SERIAL_SUB_OVF_EN, N=8:
  - a=0x80, b=0x01 → diff=0x7F, bout=0, ovf=1.
  - a=0x7F, b=0xFF → diff=0x80, bout=1, ovf=1.
  - a=0x10, b=0x01 → ovf=0.
- Start held high and a/b changed during RUN → no restart; the result matches the operands sampled at the first start. A second start in the DONE cycle → next result is done exactly 9 cycles later.
- rst asserted at cycle 4 of RUN → next cycle busy=0, done=0, diff=0, bout=0. A new start afterwards gives a correct result (a=0x20, b=0x10 → 0x10).
- N=1 instance, exhaustive a,b ∈ {0,1} → done 2 cycles after start; diff/bout = (0,0), (1,1), (1,0), (0,0) for (a,b) = (0,0), (0,1), (1,0), (1,1).
